memory_quiz: RTL and testbench
==============================

Name: memory_quiz

Overview:
- Player-facing game stage that sits directly downstream of the 9-value unique-sequence generator.
- Once the generator asserts fin, it reads the stored values through the generator's read-address/out-memory port.
- Plays them Simon-style: level L shows the first L values one at a time, then the player must key them back in order.
- Reports level, win and lose to the display/top level.

Parameters:
- NUM_ITEMS, 9, sequence length and final level (1..15).
- SHOW_TICKS, 50, tick pulses each value stays displayed.
- GAP_TICKS, 20, tick pulses of blank display between values and before input.
- TIMEOUT_TICKS, 500, tick pulses allowed between player keys before a loss.

Ports:
- clock  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- tick  in  1  1-cycle timing enable (100 Hz strobe); all timers advance only on tick
- start  in  1  level-sensitive request to begin/restart a game
- gen_fin  in  1  generator done; memory contents valid
- mem_addr  out  4  read address to generator (its readAdd)
- mem_data  in  4  value at mem_addr (generator outMem, combinational)
- key_valid  in  1  1-cycle strobe, player key present
- key_val  in  4  player key value
- disp_val  out  4  value to show; 0 when blank
- disp_on  out  1  1 while a sequence value is displayed
- level  out  4  current level 1..NUM_ITEMS; 0 in IDLE
- busy  out  1  high in every state except IDLE/WIN/LOSE
- win  out  1  held high in WIN
- lose  out  1  held high in LOSE

Behaviour:
- Interface: one clock; reset is synchronous and active-high, ports named clock and Reset.
- Reset:
  - Next clock edge with Reset=1 forces IDLE.
  - All outputs become 0, all counters clear.
  - Overrides any other input, including mid-game.
- Memory read:
  - mem_addr is registered.
  - mem_data is sampled on the clock edge after mem_addr is updated (1-cycle settle).
  - Never sample in the same cycle the address changes.
- Internal registers: lvl 4b, idx 4b, tcnt 10b (tick counter).
- IDLE: start=1 -> WAIT_GEN, lvl=1.
- WAIT_GEN: gen_fin=1 -> SHOW_LD with idx=0, mem_addr=0.
- SHOW_LD (1 cycle):
  - Latches mem_data into disp_val, sets disp_on=1.
  - tcnt=0, -> SHOW_ON.
- SHOW_ON:
  - tcnt increments on tick.
  - At tcnt==SHOW_TICKS-1 with tick: disp_on=0, disp_val=0, tcnt=0, -> SHOW_GAP.
- SHOW_GAP: at tcnt==GAP_TICKS-1 with tick:
  - if idx==lvl-1: idx=0, mem_addr=0, -> INPUT.
  - else: idx++, mem_addr=idx+1, -> SHOW_LD.
- INPUT:
  - key_valid only counts when key_val is in 1..9; out-of-range keys are ignored and do not reset the timeout.
  - Valid key: compare with mem_data (mem_addr==idx, settled).
  - Mismatch -> LOSE.
  - Match with idx==lvl-1 -> LEVEL_UP.
  - Match otherwise: idx++, mem_addr++, tcnt=0, stay in INPUT.
  - A key arriving in the cycle right after mem_addr changes is held one cycle and then compared; no key is lost.
  - tick with no key: tcnt++; tcnt reaching TIMEOUT_TICKS -> LOSE.
- LEVEL_UP (1 cycle):
  - lvl==NUM_ITEMS -> WIN.
  - Else lvl++, idx=0, mem_addr=0, -> SHOW_LD.
- WIN / LOSE:
  - Outputs held; level frozen.
  - start=1 -> WAIT_GEN, lvl=1, win/lose cleared.
- key_valid outside INPUT (including during show/gap) is ignored.
- start outside IDLE/WIN/LOSE is ignored.
- If gen_fin is already high when entering WAIT_GEN, proceed on the next cycle.
- If gen_fin drops mid-game, it is not monitored; play continues.
- Simultaneous tick and key_valid in INPUT: the key takes priority; tcnt clears to 0.
- level is driven from lvl in all states except IDLE (0).
- Arithmetic is unsigned; no counter wraps, because every bound is checked before increment.

Test Plan:
- Memory model [3,7,1,9,5,2,8,4,6], SHOW_TICKS=2, GAP_TICKS=1, tick every cycle; start -> level=1, disp_val=3 for exactly 2 ticks, then 0 for 1 tick, then INPUT.
- Same setup, player keys correct prefixes at each level -> level steps 1..9, level-9 show reads addresses 0..8 in order, win=1, busy=0, level=9.
- At level 3 player keys 3,7,2 -> lose=1 on the cycle after the third key; level stays 3; start then restarts with level=1.
- In INPUT, no key for TIMEOUT_TICKS ticks -> lose=1. A key 0 or 12 during the wait -> ignored, does not reset the timeout.
- start with gen_fin=0 -> stays WAIT_GEN with busy=1, disp_on=0. Raise gen_fin -> SHOW_LD next cycle, mem_addr=0.
- Reset asserted mid SHOW_ON at level 4 -> next edge all outputs 0, IDLE. Keys during show and a start during INPUT -> no state change.

Source files
------------

// File: rtl/memory_quiz.sv
// Simon-style memory game stage: replays the first L generator values, then checks the player's keys in order.
// Memory reads use a registered address and sample one cycle later; all timers advance only on tick.
module memory_quiz #(
  parameter int NUM_ITEMS     = 9,
  parameter int SHOW_TICKS    = 50,
  parameter int GAP_TICKS     = 20,
  parameter int TIMEOUT_TICKS = 500
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       tick,
  input  logic       start,
  input  logic       gen_fin,
  output logic [3:0] mem_addr,
  input  logic [3:0] mem_data,
  input  logic       key_valid,
  input  logic [3:0] key_val,
  output logic [3:0] disp_val,
  output logic       disp_on,
  output logic [3:0] level,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_GEN, S_SHOW_LD, S_SHOW_ON, S_SHOW_GAP,
    S_INPUT, S_LEVEL_UP, S_WIN, S_LOSE
  } state_t;

  localparam logic [9:0] SHOW_END = 10'(SHOW_TICKS - 1);
  localparam logic [9:0] GAP_END  = 10'(GAP_TICKS - 1);
  localparam logic [9:0] TO_END   = 10'(TIMEOUT_TICKS - 1);
  localparam logic [3:0] LAST_LVL = 4'(NUM_ITEMS);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_lvl;
  logic [3:0] r_idx;
  logic [9:0] r_tcnt;
  logic [3:0] r_disp_val;
  logic       r_addr_new;
  logic       r_pend;
  logic [3:0] r_pend_val;

  logic       w_key_ok;
  logic       w_last;
  logic       w_in_input;
  logic       w_hold;
  logic       w_cmp_vld;
  logic [3:0] w_cmp_val;
  logic       w_match;
  logic       w_timeout;

  // A key landing while mem_data is still settling is parked and compared on the following cycle.
  assign w_key_ok   = key_valid && (key_val >= 4'd1) && (key_val <= 4'd9);
  assign w_last     = (r_idx == r_lvl - 4'd1);
  assign w_in_input = (r_state == S_INPUT);
  assign w_hold     = w_in_input && r_addr_new && w_key_ok;
  assign w_cmp_vld  = w_in_input && !r_addr_new && (r_pend || w_key_ok);
  assign w_cmp_val  = r_pend ? r_pend_val : key_val;
  assign w_match    = (w_cmp_val == mem_data);
  assign w_timeout  = w_in_input && tick && !w_hold && !w_cmp_vld && (r_tcnt == TO_END);

  always_ff @(posedge clock) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (start) w_state_nxt = S_WAIT_GEN;
      S_WAIT_GEN: if (gen_fin) w_state_nxt = S_SHOW_LD;
      S_SHOW_LD:  w_state_nxt = S_SHOW_ON;
      S_SHOW_ON:  if (tick && r_tcnt == SHOW_END) w_state_nxt = S_SHOW_GAP;
      S_SHOW_GAP: if (tick && r_tcnt == GAP_END) w_state_nxt = w_last ? S_INPUT : S_SHOW_LD;
      S_INPUT: begin
        if (w_cmp_vld) begin
          if (!w_match)    w_state_nxt = S_LOSE;
          else if (w_last) w_state_nxt = S_LEVEL_UP;
        end else if (w_timeout) begin
          w_state_nxt = S_LOSE;
        end
      end
      S_LEVEL_UP: w_state_nxt = (r_lvl == LAST_LVL) ? S_WIN : S_SHOW_LD;
      S_WIN,
      S_LOSE:     if (start) w_state_nxt = S_WAIT_GEN;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      r_lvl      <= 4'd0;
      r_idx      <= 4'd0;
      r_tcnt     <= 10'd0;
      r_disp_val <= 4'd0;
      r_addr_new <= 1'b0;
      r_pend     <= 1'b0;
      r_pend_val <= 4'd0;
      mem_addr   <= 4'd0;
    end else begin
      r_addr_new <= 1'b0;
      case (r_state)
        S_IDLE: if (start) r_lvl <= 4'd1;
        S_WAIT_GEN: begin
          if (gen_fin) begin
            r_idx      <= 4'd0;
            mem_addr   <= 4'd0;
            r_addr_new <= 1'b1;
          end
        end
        S_SHOW_LD: begin
          r_disp_val <= mem_data;
          r_tcnt     <= 10'd0;
        end
        S_SHOW_ON: begin
          if (tick) begin
            if (r_tcnt == SHOW_END) begin
              r_tcnt     <= 10'd0;
              r_disp_val <= 4'd0;
            end else begin
              r_tcnt <= r_tcnt + 10'd1;
            end
          end
        end
        S_SHOW_GAP: begin
          if (tick) begin
            if (r_tcnt == GAP_END) begin
              r_tcnt     <= 10'd0;
              r_addr_new <= 1'b1;
              if (w_last) begin
                r_idx    <= 4'd0;
                mem_addr <= 4'd0;
              end else begin
                r_idx    <= r_idx + 4'd1;
                mem_addr <= r_idx + 4'd1;
              end
            end else begin
              r_tcnt <= r_tcnt + 10'd1;
            end
          end
        end
        S_INPUT: begin
          if (w_hold) begin
            r_pend     <= 1'b1;
            r_pend_val <= key_val;
            r_tcnt     <= 10'd0;
          end else if (w_cmp_vld) begin
            r_pend <= 1'b0;
            r_tcnt <= 10'd0;
            if (w_match && !w_last) begin
              r_idx      <= r_idx + 4'd1;
              mem_addr   <= r_idx + 4'd1;
              r_addr_new <= 1'b1;
            end
          end else if (tick && r_tcnt != TO_END) begin
            r_tcnt <= r_tcnt + 10'd1;
          end
        end
        S_LEVEL_UP: begin
          if (r_lvl != LAST_LVL) begin
            r_lvl      <= r_lvl + 4'd1;
            r_idx      <= 4'd0;
            r_tcnt     <= 10'd0;
            mem_addr   <= 4'd0;
            r_addr_new <= 1'b1;
          end
        end
        S_WIN,
        S_LOSE: begin
          if (start) begin
            r_lvl  <= 4'd1;
            r_tcnt <= 10'd0;
            r_pend <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    disp_on  = (r_state == S_SHOW_ON);
    disp_val = disp_on ? r_disp_val : 4'd0;
    level    = (r_state == S_IDLE) ? 4'd0 : r_lvl;
    busy     = !((r_state == S_IDLE) || (r_state == S_WIN) || (r_state == S_LOSE));
    win      = (r_state == S_WIN);
    lose     = (r_state == S_LOSE);
  end

endmodule

// File: tb/tb_memory_quiz.sv
// Randomized game-level bench for memory_quiz: a permutation memory model drives the read port and
// expected show sequences, key outcomes, timeouts and resets are derived from the game rules.
module tb_memory_quiz;

  localparam int NI   = 9;
  localparam int SHOW = 2;
  localparam int GAP  = 1;
  localparam int TOUT = 20;

  logic       clock = 1'b0;
  logic       Reset = 1'b1;
  logic       tick = 1'b1;
  logic       start = 1'b0;
  logic       gen_fin = 1'b0;
  logic [3:0] mem_addr;
  logic [3:0] mem_data;
  logic       key_valid = 1'b0;
  logic [3:0] key_val = 4'd0;
  logic [3:0] disp_val;
  logic       disp_on;
  logic [3:0] level;
  logic       busy;
  logic       win;
  logic       lose;

  logic [3:0] gen_mem [0:8];
  int n_chk = 0;
  int n_pass = 0;

  memory_quiz #(.NUM_ITEMS(NI), .SHOW_TICKS(SHOW), .GAP_TICKS(GAP), .TIMEOUT_TICKS(TOUT)) dut (
    .clock(clock), .Reset(Reset), .tick(tick), .start(start), .gen_fin(gen_fin),
    .mem_addr(mem_addr), .mem_data(mem_data), .key_valid(key_valid), .key_val(key_val),
    .disp_val(disp_val), .disp_on(disp_on), .level(level), .busy(busy), .win(win), .lose(lose)
  );

  always #5 clock = ~clock;

  assign mem_data = (gen_fin && mem_addr < 4'd9) ? gen_mem[mem_addr] : 4'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic shuffle();
    logic [3:0] t;
    int j;
    for (int i = 0; i < NI; i++) gen_mem[i] = 4'(i + 1);
    for (int i = NI - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = gen_mem[i]; gen_mem[i] = gen_mem[j]; gen_mem[j] = t;
    end
  endtask

  task automatic start_game();
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("start_level", level, 1);
    check_eq("start_busy", busy, 1);
    check_eq("start_win", win, 0);
    check_eq("start_lose", lose, 0);
  endtask

  // Shows value i for SHOW ticks, blanks GAP ticks plus one load cycle between values,
  // and returns positioned in the first INPUT cycle.
  task automatic show_phase(input int lvl);
    int n;
    int addr_seen;
    int stable;
    logic [3:0] v;
    for (int i = 0; i < lvl; i++) begin
      n = 0;
      addr_seen = -1;
      while (!disp_on && n < 200) begin
        addr_seen = int'(mem_addr);
        step();
        n++;
      end
      if (!disp_on) begin
        check_eq("show_start", disp_on, 1);
        return;
      end
      if (i > 0) check_eq("gap_len", n, GAP + 1);
      check_eq("show_addr", addr_seen, i);
      check_eq("show_level", level, lvl);
      v = disp_val;
      n = 0;
      stable = 1;
      while (disp_on && n < 200) begin
        if (disp_val !== v) stable = 0;
        key_valid = ($urandom_range(0, 3) == 0);
        key_val   = 4'($urandom_range(1, 9));
        step();
        key_valid = 1'b0;
        key_val   = 4'd0;
        n++;
      end
      check_eq("show_val", v, gen_mem[i]);
      check_eq("show_len", n, SHOW);
      check_eq("show_stable", stable, 1);
      check_eq("blank_val", disp_val, 0);
    end
    repeat (GAP - 1) step();
    step();
    check_eq("input_blank", disp_on, 0);
    check_eq("input_busy", busy, 1);
  endtask

  task automatic key_phase(input int lvl, input int bad_idx, input logic [3:0] bad_val);
    int gap;
    int n;
    if ($urandom_range(0, 2) == 0) begin
      start = 1'b1;
      step();
      start = 1'b0;
      check_eq("start_in_input_level", level, lvl);
      check_eq("start_in_input_busy", busy, 1);
    end
    for (int k = 0; k < lvl; k++) begin
      if (k == bad_idx) gap = 4;
      else if (k == 0)  gap = $urandom_range(1, 4);
      else              gap = $urandom_range(2, 4);
      repeat (gap - 1) step();
      key_valid = 1'b1;
      key_val   = (k == bad_idx) ? bad_val : gen_mem[k];
      step();
      key_valid = 1'b0;
      key_val   = 4'd0;
      if (k == bad_idx) begin
        check_eq("bad_key_lose", lose, 1);
        check_eq("bad_key_level", level, lvl);
        check_eq("bad_key_busy", busy, 0);
        check_eq("bad_key_win", win, 0);
        return;
      end
    end
    if (lvl == NI) begin
      n = 0;
      while (!win && n < 8) begin
        step();
        n++;
      end
      check_eq("win", win, 1);
      check_eq("win_busy", busy, 0);
      check_eq("win_level", level, NI);
      check_eq("win_lose", lose, 0);
    end else begin
      check_eq("no_lose", lose, 0);
    end
  endtask

  task automatic play_game(input int lose_lvl, input int bad_idx, input logic [3:0] bad_val);
    for (int l = 1; l <= NI; l++) begin
      show_phase(l);
      if (l == lose_lvl) begin
        key_phase(l, bad_idx, bad_val);
        return;
      end
      key_phase(l, -1, 4'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ticks;
    int tl;
    int bi;
    logic [3:0] fixed_mem [0:8];
    fixed_mem = '{4'd3, 4'd7, 4'd1, 4'd9, 4'd5, 4'd2, 4'd8, 4'd4, 4'd6};
    for (int i = 0; i < NI; i++) gen_mem[i] = fixed_mem[i];

    step();
    step();
    check_eq("rst_level", level, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_disp_on", disp_on, 0);
    check_eq("rst_disp_val", disp_val, 0);
    check_eq("rst_win", win, 0);
    check_eq("rst_lose", lose, 0);
    check_eq("rst_addr", mem_addr, 0);
    Reset = 1'b0;
    step();
    check_eq("idle_level", level, 0);

    // Generator not finished: the game waits without displaying anything.
    start_game();
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("wait_busy", busy, 1);
      check_eq("wait_disp_on", disp_on, 0);
    end
    gen_fin = 1'b1;
    step();
    check_eq("ld_addr", mem_addr, 0);
    check_eq("ld_disp_on", disp_on, 0);
    play_game(0, -1, 4'd0);
    repeat (3) step();
    check_eq("win_held", win, 1);
    check_eq("win_level_held", level, NI);

    // Level 3 with keys 3,7,2 loses on the third key.
    start_game();
    play_game(3, 2, 4'd2);
    repeat (2) step();
    check_eq("lose_held", lose, 1);
    check_eq("lose_level_held", level, 3);

    // Timeout with irregular ticks and out-of-range keys that must not count.
    shuffle();
    start_game();
    show_phase(1);
    ticks = 0;
    n = 0;
    while (!lose && n < 2000) begin
      tick = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) begin
        key_valid = 1'b1;
        case ($urandom_range(0, 3))
          0:       key_val = 4'd0;
          1:       key_val = 4'd10;
          2:       key_val = 4'd12;
          default: key_val = 4'd15;
        endcase
      end
      step();
      if (tick) ticks++;
      key_valid = 1'b0;
      key_val   = 4'd0;
      n++;
    end
    tick = 1'b1;
    check_eq("timeout_lose", lose, 1);
    check_eq("timeout_ticks", ticks, TOUT);
    check_eq("timeout_level", level, 1);

    // Random games over fresh permutations.
    for (int g = 0; g < 4; g++) begin
      shuffle();
      start_game();
      if (g == 3) begin
        play_game(0, -1, 4'd0);
      end else begin
        tl = $urandom_range(1, NI);
        bi = $urandom_range(0, tl - 1);
        play_game(tl, bi, 4'((gen_mem[bi] % 9) + 1));
        check_eq("rand_lose_level", level, tl);
      end
    end

    // Reset in the middle of the level-4 show.
    shuffle();
    start_game();
    for (int l = 1; l <= 3; l++) begin
      show_phase(l);
      key_phase(l, -1, 4'd0);
    end
    n = 0;
    while (!disp_on && n < 50) begin
      step();
      n++;
    end
    check_eq("pre_rst_disp_on", disp_on, 1);
    check_eq("pre_rst_level", level, 4);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check_eq("mid_rst_level", level, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_disp_on", disp_on, 0);
    check_eq("mid_rst_disp_val", disp_val, 0);
    check_eq("mid_rst_win", win, 0);
    check_eq("mid_rst_lose", lose, 0);
    check_eq("mid_rst_addr", mem_addr, 0);
    for (int i = 0; i < 4; i++) begin
      key_valid = 1'b1;
      key_val   = gen_mem[0];
      step();
      key_valid = 1'b0;
      check_eq("idle_stays", level, 0);
    end
    start_game();
    show_phase(1);
    key_phase(1, -1, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
